// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) between N masters, one burst outstanding.
// Optional slave-progress timeout with SLVERR completion: define AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arbiter #(
  parameter int N           = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [N-1:0]    i_m_arvalid,
  output logic [N-1:0]    o_m_arready,
  input  logic [N*49-1:0] i_m_ar,
  output logic [N-1:0]    o_m_rvalid,
  input  logic [N-1:0]    i_m_rready,
  output logic [38:0]     o_m_r,
  output logic            o_s_arvalid,
  input  logic            i_s_arready,
  output logic [48:0]     o_s_ar,
  input  logic            i_s_rvalid,
  output logic            o_s_rready,
  input  logic [38:0]     i_s_r,
  output logic [N-1:0]    o_grant,
  output logic            o_err_proto
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
`ifdef AXI_RD_ARB_TIMEOUT_EN
    ERR  = 2'd3,
`endif
    DATA = 2'd2
  } state_e;

  state_e        state, state_next;
  logic [GW-1:0] grant_idx, last_grant, pick, scan_sel;
  logic          pick_valid;
  logic [7:0]    arlen_q, beat_cnt;
  logic          err_q;
  logic [48:0]   ar_arr [N];
  logic          ar_hs, r_hs, rlast, last_beat, tmo_hit;

  for (genvar i = 0; i < N; i++) begin : g_ar_split
    assign ar_arr[i] = i_m_ar[49*i +: 49];
  end

  assign ar_hs     = (state == ADDR) && i_s_arready;
  assign r_hs      = (state == DATA) && i_s_rvalid && i_m_rready[grant_idx];
  assign rlast     = i_s_r[32];
  assign last_beat = (beat_cnt == arlen_q);

  // Round-robin scan starting just after the previous winner.
  always_comb begin
    pick       = last_grant;
    pick_valid = 1'b0;
    scan_sel   = '0;
    for (int i = 1; i <= N; i++) begin
      scan_sel = GW'((int'(last_grant) + i) % N);
      if (!pick_valid && i_m_arvalid[scan_sel]) begin
        pick_valid = 1'b1;
        pick       = scan_sel;
      end
    end
  end

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

  logic [TW-1:0] tmo_cnt;
  logic [3:0]    arid_q;
  logic          tmo_run;

  // Stalls by the master (rvalid high, rready low) hold the count rather than advance it.
  assign tmo_run = ((state == ADDR) && !i_s_arready) || ((state == DATA) && !i_s_rvalid);
  assign tmo_hit = tmo_run && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tmo_cnt <= '0;
      arid_q  <= '0;
    end else begin
      if (ar_hs || r_hs || (state == IDLE) || (state == ERR)) tmo_cnt <= '0;
      else if (tmo_run)                                       tmo_cnt <= tmo_cnt + 1'b1;
      if ((state == IDLE) && pick_valid) arid_q <= ar_arr[pick][48:45];
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  // NOTE: every state-holding element uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pick_valid) state_next = ADDR;
      ADDR: begin
        if (ar_hs) state_next = DATA;
`ifdef AXI_RD_ARB_TIMEOUT_EN
        else if (tmo_hit) state_next = ERR;
`endif
      end
      DATA: begin
        if (r_hs && rlast) state_next = IDLE;
`ifdef AXI_RD_ARB_TIMEOUT_EN
        else if (tmo_hit) state_next = ERR;
`endif
      end
`ifdef AXI_RD_ARB_TIMEOUT_EN
      ERR: if (i_m_rready[grant_idx]) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      grant_idx  <= '0;
      last_grant <= GW'(N - 1);
      arlen_q    <= '0;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      if ((state == IDLE) && pick_valid) begin
        grant_idx <= pick;
        arlen_q   <= ar_arr[pick][44:37];
      end
      if (ar_hs) beat_cnt <= '0;
      if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (rlast) last_grant <= grant_idx;
      end
`ifdef AXI_RD_ARB_TIMEOUT_EN
      if ((state == ERR) && i_m_rready[grant_idx]) last_grant <= grant_idx;
`endif
      // Length disagreement flags the beat, but rlast alone still decides where the burst ends.
      err_q <= (r_hs && (rlast != last_beat)) || ((state == IDLE) && i_s_rvalid);
    end
  end

  assign o_err_proto = err_q;

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    o_m_arready = '0;
    o_m_rvalid  = '0;
    o_m_r       = '0;
    o_s_arvalid = 1'b0;
    o_s_ar      = '0;
    o_s_rready  = 1'b0;
    o_grant     = '0;
    case (state)
      IDLE: o_s_rready = 1'b1;
      ADDR: begin
        o_s_arvalid            = 1'b1;
        o_s_ar                 = ar_arr[grant_idx];
        o_m_arready[grant_idx] = i_s_arready;
        o_grant[grant_idx]     = 1'b1;
      end
      DATA: begin
        o_m_rvalid[grant_idx] = i_s_rvalid;
        o_s_rready            = i_m_rready[grant_idx];
        o_m_r                 = i_s_r;
        o_grant[grant_idx]    = 1'b1;
      end
`ifdef AXI_RD_ARB_TIMEOUT_EN
      ERR: begin
        o_m_rvalid[grant_idx] = 1'b1;
        o_s_rready            = 1'b1;
        o_m_r                 = {arid_q, 2'b10, 1'b1, 32'h0};
        o_grant[grant_idx]    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (N=2); the timeout scenario follows AXI_RD_ARB_TIMEOUT_EN.
module tb_axi_rd_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [1:0]  i_m_arvalid, o_m_arready, o_m_rvalid, i_m_rready, o_grant;
  logic [97:0] i_m_ar;
  logic [38:0] o_m_r, i_s_r;
  logic        o_s_arvalid, i_s_arready, i_s_rvalid, o_s_rready, o_err_proto;
  logic [48:0] o_s_ar;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 i_clock = ~i_clock;

  axi_rd_arbiter #(.N(2), .TIMEOUT_CYC(16)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_m_arvalid(i_m_arvalid),
    .o_m_arready(o_m_arready),
    .i_m_ar     (i_m_ar),
    .o_m_rvalid (o_m_rvalid),
    .i_m_rready (i_m_rready),
    .o_m_r      (o_m_r),
    .o_s_arvalid(o_s_arvalid),
    .i_s_arready(i_s_arready),
    .o_s_ar     (o_s_ar),
    .i_s_rvalid (i_s_rvalid),
    .o_s_rready (o_s_rready),
    .i_s_r      (i_s_r),
    .o_grant    (o_grant),
    .o_err_proto(o_err_proto)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  function automatic logic [48:0] mk_ar(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
    return {id, len, 3'd2, 2'b01, addr};
  endfunction

  function automatic logic [38:0] mk_r(input logic [3:0] id, input logic last, input logic [31:0] data);
    return {id, 2'b00, last, data};
  endfunction

  logic [48:0] ar0, ar1;
  logic [38:0] rb;
  logic [1:0]  exp_oh;

  initial begin
    i_reset = 1'b0; i_m_arvalid = '0; i_m_ar = '0; i_m_rready = '0;
    i_s_arready = 1'b0; i_s_rvalid = 1'b0; i_s_r = '0;
    repeat (2) @(negedge i_clock);
    check("rst_grant", o_grant, 0);
    check("rst_s_arvalid", o_s_arvalid, 0);
    check("rst_s_rready", o_s_rready, 1);
    check("rst_m_rvalid", o_m_rvalid, 0);
    check("rst_m_arready", o_m_arready, 0);
    check("rst_err", o_err_proto, 0);
    check("rst_s_ar", o_s_ar, 0);
    i_reset = 1'b1;
    tick();

    // Simultaneous requests: master 0 first, then master 1 after one idle bubble.
    ar0 = mk_ar(4'd1, 8'd0, 32'h0000_1000);
    ar1 = mk_ar(4'd2, 8'd3, 32'h8000_0000);
    i_m_ar = {ar1, ar0}; i_m_arvalid = 2'b11; #1;
    check("t1_arvalid_same_cycle", o_s_arvalid, 0);
    tick();
    check("t1_grant0", o_grant, 2'b01);
    check("t1_s_arvalid", o_s_arvalid, 1);
    check("t1_s_ar0", o_s_ar, ar0);
    check("t1_arready_wait", o_m_arready, 2'b00);
    i_s_arready = 1'b1; #1;
    check("t1_arready_pass", o_m_arready, 2'b01);
    tick();
    i_m_arvalid = 2'b10; i_s_arready = 1'b0; i_m_rready = 2'b11;
    rb = mk_r(4'd1, 1'b1, 32'hDEAD_0001); i_s_rvalid = 1'b1; i_s_r = rb; #1;
    check("t1_rvalid", o_m_rvalid, 2'b01);
    check("t1_r_payload", o_m_r, rb);
    check("t1_s_rready", o_s_rready, 1);
    tick();
    i_s_rvalid = 1'b0; #1;
    check("t1_bubble", o_grant, 2'b00);
    tick();
    check("t1_grant1", o_grant, 2'b10);
    check("t1_s_ar1", o_s_ar, ar1);

    // Master 1, arlen=3: exactly four beats routed to master 1, no anomaly.
    i_s_arready = 1'b1; tick();
    i_s_arready = 1'b0; i_m_arvalid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      i_s_rvalid = 1'b1; i_s_r = mk_r(4'd2, (k == 3), 32'h1000 + k); #1;
      check("t2_beat_rvalid", o_m_rvalid, 2'b10);
      tick();
      check("t2_beat_err", o_err_proto, 0);
    end
    i_s_rvalid = 1'b0; #1;
    check("t2_back_idle", o_grant, 2'b00);

    // Master stalls R for 5 cycles: slave is back-pressured, payload held, no beat lost.
    i_m_ar[48:0] = mk_ar(4'd3, 8'd1, 32'h0000_2000); i_m_arvalid = 2'b01;
    tick();
    i_s_arready = 1'b1; tick();
    i_s_arready = 1'b0; i_m_arvalid = 2'b00; i_m_rready = 2'b10;
    rb = mk_r(4'd3, 1'b0, 32'hAAAA_0000); i_s_rvalid = 1'b1; i_s_r = rb;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_stall_rready", o_s_rready, 0);
      check("t5_stall_payload", o_m_r, rb);
      tick();
    end
    i_m_rready = 2'b11; #1;
    check("t5_release_rready", o_s_rready, 1);
    tick();
    rb = mk_r(4'd3, 1'b1, 32'hAAAA_0001); i_s_r = rb; #1;
    check("t5_second_beat", o_m_r, rb);
    tick();
    check("t5_no_err", o_err_proto, 0);
    check("t5_done", o_grant, 2'b00);
    i_s_rvalid = 1'b0;

    // Early rlast on beat 2 of arlen=3: one pulse, burst still ends.
    i_m_ar[97:49] = mk_ar(4'd4, 8'd3, 32'h0000_3000); i_m_arvalid = 2'b10;
    tick();
    check("t4_grant", o_grant, 2'b10);
    i_s_arready = 1'b1; tick();
    i_s_arready = 1'b0; i_m_arvalid = 2'b00;
    i_s_rvalid = 1'b1; i_s_r = mk_r(4'd4, 1'b0, 32'h0); tick();
    check("t4_beat1_err", o_err_proto, 0);
    i_s_r = mk_r(4'd4, 1'b1, 32'h1); tick();
    check("t4_pulse", o_err_proto, 1);
    check("t4_idle", o_grant, 2'b00);
    i_s_rvalid = 1'b0; tick();
    check("t4_pulse_once", o_err_proto, 0);

    // Stray beat in IDLE is sunk and flagged.
    i_s_rvalid = 1'b1; i_s_r = mk_r(4'd9, 1'b1, 32'h5); #1;
    check("stray_rready", o_s_rready, 1);
    check("stray_no_rvalid", o_m_rvalid, 2'b00);
    tick();
    check("stray_err", o_err_proto, 1);
    i_s_rvalid = 1'b0; tick();
    check("stray_err_clear", o_err_proto, 0);

    // Reset in the middle of a burst returns straight to the reset state.
    i_m_ar[48:0] = mk_ar(4'd5, 8'd7, 32'h0000_4000); i_m_arvalid = 2'b01;
    tick();
    i_s_arready = 1'b1; tick();
    i_s_arready = 1'b0; i_m_arvalid = 2'b00;
    i_s_rvalid = 1'b1; i_s_r = mk_r(4'd5, 1'b0, 32'h0); tick();
    check("midrst_busy", o_grant, 2'b01);
    i_reset = 1'b0; #1;
    check("midrst_grant", o_grant, 2'b00);
    check("midrst_s_rready", o_s_rready, 1);
    check("midrst_m_rvalid", o_m_rvalid, 2'b00);
    i_s_rvalid = 1'b0; tick();
    i_reset = 1'b1; tick();

    // Both masters request continuously: grants alternate 0,1,0,1,0,1.
    i_m_ar = {mk_ar(4'd7, 8'd0, 32'h0000_5000), mk_ar(4'd6, 8'd0, 32'h0000_6000)};
    i_m_arvalid = 2'b11; exp_oh = 2'b01;
    for (int t = 0; t < 6; t++) begin
      tick();
      check("t3_grant", o_grant, exp_oh);
      i_s_arready = 1'b1; tick();
      i_s_arready = 1'b0;
      i_s_rvalid = 1'b1; i_s_r = mk_r(4'd6, 1'b1, 32'h100 + t); #1;
      check("t3_rvalid", o_m_rvalid, exp_oh);
      tick();
      i_s_rvalid = 1'b0;
      check("t3_err", o_err_proto, 0);
      exp_oh = ~exp_oh;
    end
    i_m_arvalid = 2'b00;
    tick();

    // Slave never accepts AR.
    i_m_rready = 2'b00;
    i_m_ar[48:0] = mk_ar(4'hA, 8'd0, 32'h0000_7000); i_m_arvalid = 2'b01;
    tick();
`ifdef AXI_RD_ARB_TIMEOUT_EN
    repeat (15) tick();
    check("t6_still_addr", o_s_arvalid, 1);
    check("t6_no_rvalid_yet", o_m_rvalid, 2'b00);
    tick();
    check("t6_err_rvalid", o_m_rvalid, 2'b01);
    check("t6_err_payload", o_m_r, {4'hA, 2'b10, 1'b1, 32'h0});
    check("t6_err_arvalid", o_s_arvalid, 0);
    check("t6_err_sink", o_s_rready, 1);
    i_m_arvalid = 2'b00; i_m_rready = 2'b01;
    tick();
    check("t6_exit_idle", o_grant, 2'b00);
`else
    repeat (20) tick();
    check("t6_hang_arvalid", o_s_arvalid, 1);
    check("t6_hang_grant", o_grant, 2'b01);
    i_m_arvalid = 2'b00; i_reset = 1'b0; tick();
    i_reset = 1'b1; tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
